window3x3_gen: RTL
==================

# window3x3_gen

Streaming sliding-window generator that sits directly upstream of the 3x3 convolution stage. It accepts a raster-order pixel stream (row-major, one pixel per transfer) and keeps the two previous image rows in internal line buffers. For every pixel that completes a full 3x3 neighbourhood, it emits that neighbourhood as a packed window ready for the convolution datapath. Borders are not padded: only fully interior windows are produced.

## Interface
Parameters:
- IMG_W, 32: image width in pixels; legal range 3..1024.
- IMG_H, 32: image height in pixels; legal range 3..1024.
- DATA_W, 8: pixel width in bits.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream pixel valid.
- in_ready  out  1  block can accept a pixel; equals !out_valid || out_ready.
- in_data  in  DATA_W  pixel value, raster order.
- out_valid  out  1  window valid.
- out_ready  in  1  downstream accepts window.
- out_window  out  [2:0][2:0][DATA_W-1:0]  window; out_window[i][j] = pixel(row-2+i, col-2+j).
- out_last  out  1  high with the final window of a frame.

## Operation
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Counters: col in 0..IMG_W-1 and row in 0..IMG_H-1 give the position of the pixel being accepted.
  - col increments on each input transfer.
  - At col == IMG_W-1, col wraps to 0 and row increments.
  - At the last pixel of the frame, row also wraps to 0. The next frame starts with no extra signalling.
- Line buffers: lb1 holds row-1 and lb0 holds row-2, each IMG_W deep, indexed by col. On each input transfer at column c:
  - the old lb1[c] is written to lb0[c];
  - in_data is written to lb1[c];
  - the old lb0[c], the old lb1[c] and in_data are shifted into a 3x3 shift register as a new right-hand column (column j=2). Existing columns shift left.
- Window emit: on an input transfer with row >= 2 and col >= 2, the shift register contents after the shift are loaded into out_window and out_valid is set. This yields (IMG_W-2)*(IMG_H-2) windows per frame.
- out_last is loaded as 1 when the transfer is at row == IMG_H-1 and col == IMG_W-1, and 0 otherwise.
- No output is produced for transfers at row < 2 or col < 2.
- Shift register contents carry across row boundaries. This is harmless because col >= 2 gating discards any mixed-row windows.
- Output register:
  - out_valid clears on an output transfer when no new window is loaded in the same cycle.
  - If an output transfer and a window-producing input transfer occur in the same cycle, the new window replaces the old one and out_valid stays 1.
- Backpressure: while out_valid && !out_ready, in_ready is 0. Counters, line buffers and the shift register hold their state.
- Arithmetic: pixels pass through unmodified. Counters are $clog2(IMG_W) and $clog2(IMG_H) bits wide.

## Timing
- Reset (asynchronous, takes effect immediately): out_valid=0, out_last=0, out_window=0, col=0, row=0, shift register=0. in_ready reads 1 immediately because out_valid=0.
- Line buffer contents are not reset. The row >= 2 gating guarantees stale data is never emitted.
- Latency: a window appears on out_window / out_valid in the cycle after its bottom-right pixel is accepted.
- Throughput: one pixel per cycle and one window per cycle in steady state when out_ready=1.
- Reset mid-frame: the partial frame is discarded. The next pixel accepted after reset release is treated as pixel (0,0).
- No combinational path from in_valid or in_data to any output. The only combinational path is out_ready -> in_ready.

## Structure
- Shared package vt512_conv_pkg holds:
  - the pixel_t typedef (logic [7:0]);
  - the window_t typedef ([2:0][2:0] pixel_t), shared with the convolution stage;
  - the constant WIN = 3.
- One sub-module, line_buf_ram: single-port, read-before-write, IMG_W x DATA_W array. It is instantiated twice (lb0, lb1) and is replaceable by an SRAM macro later.
- Counters, shift register and output register stay in the top module.

## Test plan
- IMG_W=4, IMG_H=4, pixels 0..15, out_ready=1 -> exactly 4 windows:
  - first window {0,1,2; 4,5,6; 8,9,10};
  - fourth window {5,6,7; 9,10,11; 13,14,15} with out_last=1;
  - no other out_last.
- Same stimulus with out_ready low for 3 cycles at the first window -> in_ready=0 during the stall; window held stable; no pixels lost; same 4 windows produced.
- Two back-to-back frames (pixels 0..15, then 100..115) -> the second frame's first window is {100,101,102; 104,105,106; 108,109,110}. No window mixes data from the two frames.
- Assert rst after 9 pixels of a frame, then send 0..15 -> output is identical to the first scenario. Outputs read 0 during reset.
- in_valid toggling randomly, out_ready=1 -> window sequence identical to the continuous case.
- IMG_W=3, IMG_H=3, pixels 1..9 -> a single window {1,2,3; 4,5,6; 7,8,9} with out_last=1, one cycle after pixel 9 is accepted.

Source files
------------

// File: rtl/vt512_conv_pkg.sv
// Types and constants shared between the window generator and the 3x3 convolution stage.
package vt512_conv_pkg;

  localparam int unsigned WIN = 3;

  typedef logic [7:0] pixel_t;
  typedef pixel_t [WIN-1:0][WIN-1:0] window_t;

endpackage

// File: rtl/window3x3_gen_line_buf_ram.sv
// Single-port read-before-write line buffer; read is asynchronous so the old entry
// is visible in the same cycle it is overwritten. Swappable for an SRAM macro.
module line_buf_ram #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/window3x3_gen.sv
// Raster-stream 3x3 sliding-window generator: two line buffers, a 3x3 shift register
// and a registered output; emits only fully interior windows.
module window3x3_gen
  import vt512_conv_pkg::*;
#(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int DATA_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2:0][2:0][DATA_W-1:0]   out_window,
  output logic                          out_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef logic [WIN-1:0][WIN-1:0][DATA_W-1:0] win_t;

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] lb0_rd;
  logic [DATA_W-1:0] lb1_rd;
  win_t              shreg;
  win_t              shreg_next;
  logic              accept;
  logic              emit;
  logic              col_end;
  logic              row_end;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign col_end  = (col == CW'(IMG_W - 1));
  assign row_end  = (row == RW'(IMG_H - 1));
  assign emit     = accept && (row >= RW'(2)) && (col >= CW'(2));

  // lb1 holds row-1, lb0 holds row-2; each transfer ages lb1[col] into lb0[col].
  line_buf_ram #(
    .DEPTH  (IMG_W),
    .DATA_W (DATA_W),
    .ADDR_W (CW)
  ) lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (lb1_rd),
    .rdata (lb0_rd)
  );

  line_buf_ram #(
    .DEPTH  (IMG_W),
    .DATA_W (DATA_W),
    .ADDR_W (CW)
  ) lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (in_data),
    .rdata (lb1_rd)
  );

  always_comb begin
    shreg_next = shreg;
    for (int unsigned i = 0; i < WIN; i++) begin
      shreg_next[i][0] = shreg[i][1];
      shreg_next[i][1] = shreg[i][2];
    end
    shreg_next[0][2] = lb0_rd;
    shreg_next[1][2] = lb1_rd;
    shreg_next[2][2] = in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col   <= '0;
      row   <= '0;
      shreg <= '0;
    end else if (accept) begin
      shreg <= shreg_next;
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // A new window wins over retiring the old one, so out_valid stays set on overlap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_window <= '0;
    end else if (emit) begin
      out_valid  <= 1'b1;
      out_last   <= row_end && col_end;
      out_window <= shreg_next;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
